regfile_scoreboard: RTL

- Parametrised multi-port MIPS register file with an integrated per-register scoreboard (busy bits) for the pipelined CPU.
- Two combinational read ports, one synchronous write-back port, an issue port that reserves destination registers, and a selectable debug read port.
- Sits between decode (reads, issue) and write-back. Provides the hazard information the pipeline controller uses to stall.

---
 rtl/regfile_scoreboard_if.sv | 52 +++++
 rtl/regfile_scoreboard.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Pipeline-facing bundle of the register file: reads, write-back, issue and debug.
// Latency: wiring only; timing is set by the register file behind the slave modport.
// Backpressure: Issue_Ready answers Issue_Valid in the same cycle; no other flow control.
interface regfile_scoreboard_if #(
    parameter int ADDR = 5,
    parameter int SIZE = 32
);
    // write-back
    logic            Write_Reg;
    logic [ADDR-1:0] W_Addr;
    logic [SIZE-1:0] W_Data;

    // decode reads
    logic [ADDR-1:0] R_Addr_A;
    logic [ADDR-1:0] R_Addr_B;
    logic [SIZE-1:0] R_Data_A;
    logic [SIZE-1:0] R_Data_B;
    logic            R_Busy_A;
    logic            R_Busy_B;

    // destination reservation
    logic            Issue_Valid;
    logic [ADDR-1:0] Issue_Addr;
    logic            Issue_Ready;
    logic [ADDR:0]   Busy_Count;

    // debug read, never bypassed
    logic [ADDR-1:0] Dbg_Addr;
    logic [SIZE-1:0] Dbg_Data;

    // Pipeline side: decode, write-back and debug logic.
    modport master (
        output Write_Reg, W_Addr, W_Data,
        output R_Addr_A, R_Addr_B,
        output Issue_Valid, Issue_Addr,
        output Dbg_Addr,
        input  R_Data_A, R_Data_B, R_Busy_A, R_Busy_B,
        input  Issue_Ready, Busy_Count,
        input  Dbg_Data
    );

    // Register file side.
    modport slave (
        input  Write_Reg, W_Addr, W_Data,
        input  R_Addr_A, R_Addr_B,
        input  Issue_Valid, Issue_Addr,
        input  Dbg_Addr,
        output R_Data_A, R_Data_B, R_Busy_A, R_Busy_B,
        output Issue_Ready, Busy_Count,
        output Dbg_Data
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// MIPS register file with per-register busy bits for hazard detection; REGFILE_BYPASS_EN adds write-to-read forwarding.
// Latency: reads, busy flags and Issue_Ready are combinational; data, busy bits and Busy_Count update on the rising Clk edge.
// Backpressure: Issue_Ready drops while the destination is still owned by an older write-back; the caller must stall and retry.
module regfile_scoreboard #(
    parameter int ADDR = 5,
    localparam int NUMB = 1 << ADDR,
    parameter int SIZE = 32,
    parameter int ZERO_REG = 1
) (
    input  logic Clk,
    input  logic Clr,
    regfile_scoreboard_if.slave bus
);

    // Register 0 is hard-wired to zero and never owned by anybody when this is set.
    localparam bit ZR = (ZERO_REG != 0);
    localparam logic [ADDR:0] CNT_ONE = 1;

    logic [SIZE-1:0] regs [NUMB];
    logic [NUMB-1:0] busy;
    logic [NUMB-1:0] busy_next;
    logic [ADDR:0]   busy_count;
    logic [ADDR:0]   count_next;

    logic            wr_en;
    logic            issue_zero;
    logic            issue_ready;
    logic            issue_take;
    logic            count_inc;
    logic            count_dec;

    logic [SIZE-1:0] rd_a;
    logic [SIZE-1:0] rd_b;
    logic [SIZE-1:0] rd_dbg;
    logic            busy_a;
    logic            busy_b;

    // Decide whether this cycle's write-back lands and whether the issue is accepted.
    always_comb begin
        wr_en       = bus.Write_Reg && !(ZR && (bus.W_Addr == '0));
        issue_zero  = ZR && (bus.Issue_Addr == '0);
        // A same-cycle write-back to the destination frees it in time for the new owner.
        issue_ready = bus.Issue_Valid &&
                      (!busy[bus.Issue_Addr] ||
                       (bus.Write_Reg && (bus.W_Addr == bus.Issue_Addr)) ||
                       issue_zero);
        // An accepted issue to a hard-wired zero register reserves nothing.
        issue_take  = issue_ready && !issue_zero;
    end

    // Next busy vector: write-back clears, an accepted issue sets and wins over the clear.
    always_comb begin
        busy_next = busy;
        if (bus.Write_Reg) begin
            busy_next[bus.W_Addr] = 1'b0;
        end
        if (issue_take) begin
            busy_next[bus.Issue_Addr] = 1'b1;
        end
        if (ZR) begin
            busy_next[0] = 1'b0;
        end
    end

    // Track popcount(busy) incrementally so the count never needs an adder tree.
    always_comb begin
        // Only a newly reserved register adds one; re-owning a register being freed is net zero.
        count_inc  = issue_take && !busy[bus.Issue_Addr];
        // A clear counts only if the bit was set and the same edge does not re-set it.
        count_dec  = bus.Write_Reg && busy[bus.W_Addr] &&
                     !(issue_take && (bus.Issue_Addr == bus.W_Addr));
        count_next = busy_count;
        if (count_inc && !count_dec) begin
            count_next = busy_count + CNT_ONE;
        end else if (count_dec && !count_inc) begin
            count_next = busy_count - CNT_ONE;
        end
    end

    // Register storage: cleared asynchronously, written on the rising edge.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            for (int i = 0; i < NUMB; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.W_Addr] <= bus.W_Data;
        end
    end

    // Scoreboard state: busy bits and their running count.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    // Port A read with optional forwarding of the write-back in flight.
    always_comb begin
        rd_a   = regs[bus.R_Addr_A];
        busy_a = busy[bus.R_Addr_A];
        if (ZR && (bus.R_Addr_A == '0)) begin
            rd_a   = '0;
            busy_a = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        // wr_en already excludes a suppressed register 0, so zero stays zero.
        if (wr_en && (bus.W_Addr == bus.R_Addr_A)) begin
            rd_a   = bus.W_Data;
            busy_a = 1'b0;
        end
`endif
    end

    // Port B read with optional forwarding of the write-back in flight.
    always_comb begin
        rd_b   = regs[bus.R_Addr_B];
        busy_b = busy[bus.R_Addr_B];
        if (ZR && (bus.R_Addr_B == '0)) begin
            rd_b   = '0;
            busy_b = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (bus.W_Addr == bus.R_Addr_B)) begin
            rd_b   = bus.W_Data;
            busy_b = 1'b0;
        end
`endif
    end

    // Debug port always shows architectural state, never the value in flight.
    always_comb begin
        rd_dbg = regs[bus.Dbg_Addr];
        if (ZR && (bus.Dbg_Addr == '0)) begin
            rd_dbg = '0;
        end
    end

    assign bus.R_Data_A    = rd_a;
    assign bus.R_Data_B    = rd_b;
    assign bus.R_Busy_A    = busy_a;
    assign bus.R_Busy_B    = busy_b;
    assign bus.Issue_Ready = issue_ready;
    assign bus.Busy_Count  = busy_count;
    assign bus.Dbg_Data    = rd_dbg;

endmodule
